// File: rtl/cache_pkg.sv
// Shared types and constants for the cache block-fill path.
// Default block geometry: 8 x 16-bit words (16 bytes) per block, 16-bit byte addresses.
package cache_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_BITS = 4;
    localparam int IDX_W       = $clog2(BLOCK_WORDS);
    localparam int CNT_W       = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GRANT,
        FILL,
        DONE
    } fill_state_t;

    // Byte address of word idx inside the block starting at base (wraps modulo 2^ADDR_W).
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [IDX_W-1:0]  idx);
        return base + ADDR_W'({idx, 1'b0});
    endfunction

endpackage

// File: rtl/block_word_counter.sv
// Word counter for one block: clear, enable, saturation at BLOCK_WORDS,
// and an index output rotated by a start offset (wraps inside the block).
module block_word_counter
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [IDX_W-1:0] start,
    output logic [CNT_W-1:0] count,
    output logic [IDX_W-1:0] idx
);

    logic full;

    assign full = (count == CNT_W'(BLOCK_WORDS));
    assign idx  = start + count[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !full) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Per-cache miss handler: requests the memory port, issues block word reads and streams
// the returned words into the cache. Option macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN.
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              grant,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              req,
    output logic              fsm_busy,
    output logic              memory_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_tag_array
);

    fill_state_t       state, state_next;
    logic [ADDR_W-1:0] base;
    logic [IDX_W-1:0]  crit_idx;
    logic [CNT_W-1:0]  issue_cnt, recv_cnt;
    logic [IDX_W-1:0]  issue_idx, recv_idx;
    logic              start_miss, issue_fire, recv_fire;
    logic              unused_offset_bits;

    assign unused_offset_bits = ^miss_address[OFFSET_BITS-1:0];

    assign start_miss = (state == IDLE) && miss_detected;
    assign issue_fire = (state == FILL) && grant && (issue_cnt != CNT_W'(BLOCK_WORDS));
    assign recv_fire  = (state == FILL) && memory_data_valid && (recv_cnt != CNT_W'(BLOCK_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base     <= '0;
            crit_idx <= '0;
        end else begin
            state <= state_next;
            if (start_miss) begin
                base <= {miss_address[ADDR_W-1:OFFSET_BITS], OFFSET_BITS'(0)};
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                crit_idx <= miss_address[OFFSET_BITS-1:1];
`else
                crit_idx <= '0;
`endif
            end
        end
    end

    block_word_counter u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_miss),
        .en    (issue_fire),
        .start (crit_idx),
        .count (issue_cnt),
        .idx   (issue_idx)
    );

    block_word_counter u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_miss),
        .en    (recv_fire),
        .start (crit_idx),
        .count (recv_cnt),
        .idx   (recv_idx)
    );

    always_comb begin
        state_next       = state;
        req              = 1'b0;
        fsm_busy         = 1'b0;
        memory_read_en   = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_addr        = '0;
        fill_data        = '0;
        write_tag_array  = 1'b0;
        case (state)
            IDLE: begin
                if (miss_detected) state_next = WAIT_GRANT;
            end
            WAIT_GRANT: begin
                req      = 1'b1;
                fsm_busy = 1'b1;
                if (grant) state_next = FILL;
            end
            FILL: begin
                req = 1'b1;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                // Pipeline restarts once the critical word has landed; the rest fills behind it.
                fsm_busy = (recv_cnt == '0);
`else
                fsm_busy = 1'b1;
`endif
                if (issue_fire) begin
                    memory_read_en = 1'b1;
                    memory_address = word_addr(base, issue_idx);
                end
                if (recv_fire) begin
                    write_data_array = 1'b1;
                    fill_addr        = word_addr(base, recv_idx);
                    fill_data        = memory_data;
                    if (recv_cnt == CNT_W'(BLOCK_WORDS - 1)) state_next = DONE;
                end
            end
            DONE: begin
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                fsm_busy = 1'b0;
`else
                fsm_busy = 1'b1;
`endif
                write_tag_array = 1'b1;
                fill_addr       = base;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-cycle in-order memory model and
// expected-address queues for issued reads and cache writes.
module tb_cache_fill_fsm;
    import cache_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              miss_detected = 1'b0;
    logic [ADDR_W-1:0] miss_address = '0;
    logic              grant = 1'b0;
    logic              memory_data_valid = 1'b0;
    logic [DATA_W-1:0] memory_data = '0;
    logic              req, fsm_busy, memory_read_en, write_data_array, write_tag_array;
    logic [ADDR_W-1:0] memory_address, fill_addr;
    logic [DATA_W-1:0] fill_data;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .grant             (grant),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .req               (req),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_addr         (fill_addr),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // scoreboard / model state
    logic [ADDR_W-1:0] exp_rd_q[$];
    logic [ADDR_W-1:0] exp_wr_q[$];
    int                due_q[$];
    logic [ADDR_W-1:0] due_a[$];
    int                rd_cyc[$];
    logic [ADDR_W-1:0] exp_base, first_rd_addr;
    int n_rd, n_wr, n_tag, n_busy, first_wr_cyc, tag_cyc, miss_cyc;
    bit grant_drv, miss_drv, junk_drv;
    logic [ADDR_W-1:0] maddr_drv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, {31'd0, req}, 0);
        check({tag, "_busy"}, {31'd0, fsm_busy}, 0);
        check({tag, "_rd_en"}, {31'd0, memory_read_en}, 0);
        check({tag, "_mem_addr"}, {16'd0, memory_address}, 0);
        check({tag, "_wr"}, {31'd0, write_data_array}, 0);
        check({tag, "_fill_addr"}, {16'd0, fill_addr}, 0);
        check({tag, "_fill_data"}, {16'd0, fill_data}, 0);
        check({tag, "_tag"}, {31'd0, write_tag_array}, 0);
    endtask

    // One clock: drive at the falling edge, observe 1ns later, well before the rising edge.
    task automatic cycle();
        logic [ADDR_W-1:0] a;
        @(negedge clk);
        grant         = grant_drv;
        miss_detected = miss_drv;
        miss_address  = maddr_drv;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            memory_data_valid = 1'b1;
            memory_data       = due_a[0] ^ 16'hBEEF;
            void'(due_q.pop_front());
            void'(due_a.pop_front());
        end else if (junk_drv) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'hDEAD;
        end else begin
            memory_data_valid = 1'b0;
            memory_data       = '0;
        end
        #1;
        if (fsm_busy) n_busy++;
        if (memory_read_en) begin
            if (n_rd == 0) first_rd_addr = memory_address;
            n_rd++;
            rd_cyc.push_back(cyc);
            if (exp_rd_q.size() == 0) check("rd_extra", 1, 0);
            else check("rd_addr", {16'd0, memory_address}, {16'd0, exp_rd_q.pop_front()});
            due_q.push_back(cyc + 4);
            due_a.push_back(memory_address);
        end
        if (write_data_array) begin
            if (n_wr == 0) first_wr_cyc = cyc;
            n_wr++;
            if (exp_wr_q.size() == 0) check("wr_extra", 1, 0);
            else begin
                a = exp_wr_q.pop_front();
                check("wr_addr", {16'd0, fill_addr}, {16'd0, a});
                check("wr_data", {16'd0, fill_data}, {16'd0, a ^ 16'hBEEF});
            end
        end
        if (write_tag_array) begin
            n_tag++;
            tag_cyc = cyc;
            check("tag_addr", {16'd0, fill_addr}, {16'd0, exp_base});
        end
        cyc++;
    endtask

    task automatic prep(input logic [ADDR_W-1:0] maddr);
        int start;
        exp_base = {maddr[15:4], 4'h0};
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        start = int'(maddr[3:1]);
`else
        start = 0;
`endif
        exp_rd_q.delete(); exp_wr_q.delete(); due_q.delete(); due_a.delete(); rd_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            exp_rd_q.push_back(exp_base + 16'(2 * ((start + i) % 8)));
            exp_wr_q.push_back(exp_base + 16'(2 * ((start + i) % 8)));
        end
        n_rd = 0; n_wr = 0; n_tag = 0; n_busy = 0; first_wr_cyc = 0; tag_cyc = 0;
    endtask

    // Runs one fill; returns early (aborted=1) once abort_words words were written.
    task automatic run_fill(input logic [ADDR_W-1:0] maddr, input int gap_after, input int gap_len,
                            input int abort_words, input bit second_miss, output bit aborted);
        int  gap_left;
        bit  gap_done;
        prep(maddr);
        gap_left = 0; gap_done = 0; aborted = 0;
        miss_drv = 1; maddr_drv = maddr; grant_drv = 1; junk_drv = 0;
        cycle();
        miss_cyc = cyc - 1;
        miss_drv = 0;
        for (int k = 0; k < 60 && n_tag == 0; k++) begin
            if (abort_words >= 0 && n_wr == abort_words) begin
                aborted = 1;
                return;
            end
            if (gap_after >= 0 && n_rd == gap_after && !gap_done) begin
                gap_left = gap_len;
                gap_done = 1;
            end
            grant_drv = (gap_left == 0);
            if (gap_left > 0) gap_left--;
            miss_drv  = second_miss && (n_rd == 3);
            maddr_drv = second_miss ? 16'h7777 : maddr;
            cycle();
        end
        miss_drv = 0;
        check("tag_count", n_tag, 1);
        check("rd_count", n_rd, 8);
        check("wr_count", n_wr, 8);
        check("rd_q_left", exp_rd_q.size(), 0);
        check("wr_q_left", exp_wr_q.size(), 0);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        check("busy_cycles", n_busy, first_wr_cyc - miss_cyc);
`else
        check("busy_cycles", n_busy, tag_cyc - miss_cyc);
`endif
        grant_drv = 0;
        cycle();
        check("idle_busy", {31'd0, fsm_busy}, 0);
        check("idle_req", {31'd0, req}, 0);
    endtask

    bit ab;

    initial begin
        grant_drv = 0; miss_drv = 0; junk_drv = 0; maddr_drv = '0;
        // reset state
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // baseline fill at 0x1236, grant held
        run_fill(16'h1236, -1, 0, -1, 0, ab);
        check("t1_latency", tag_cyc - miss_cyc, 14);
        check("t1_rd_burst", rd_cyc[7] - rd_cyc[0], 7);
        check("t1_first_rd_gap", rd_cyc[0] - miss_cyc, 2);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        check("t1_first_rd", {16'd0, first_rd_addr}, 32'h1236);
`else
        check("t1_first_rd", {16'd0, first_rd_addr}, 32'h1230);
        check("t1_busy", n_busy, 14);
`endif

        // grant dropped for 3 cycles after the 2nd issue
        run_fill(16'h4450, 2, 3, -1, 0, ab);
        check("t2_gap", rd_cyc[2] - rd_cyc[1], 4);
        check("t2_tail", rd_cyc[7] - rd_cyc[2], 5);
        check("t2_head", rd_cyc[1] - rd_cyc[0], 1);

        // asynchronous reset mid-fill after 5 words
        run_fill(16'h2002, -1, 0, 5, 0, ab);
        check("t3_aborted", {31'd0, ab}, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("t3_abort");
        check("t3_no_tag", n_tag, 0);
        due_q.delete(); due_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        grant_drv = 0;
        repeat (3) cycle();
        check("t3_quiet_wr", n_wr, 5);
        check("t3_quiet_tag", n_tag, 0);
        run_fill(16'h0040, -1, 0, -1, 0, ab);
        check("t3_refill_first_wr", {16'd0, exp_base}, 32'h0040);

        // stray data-valid in IDLE, second miss during FILL
        prep(16'h0000);
        junk_drv = 1;
        repeat (3) cycle();
        junk_drv = 0;
        check("t4_idle_wr", n_wr, 0);
        check("t4_idle_rd", n_rd, 0);
        run_fill(16'h3118, -1, 0, -1, 1, ab);
        repeat (4) cycle();
        check("t4_no_refill", n_rd, 8);
        check("t4_no_extra_tag", n_tag, 1);

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        // critical word first
        run_fill(16'hA00A, -1, 0, -1, 0, ab);
        check("t5_first_rd", {16'd0, first_rd_addr}, 32'hA00A);
        check("t5_busy", n_busy, 6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
